// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder: FSM state encoding and
// the counter-width function.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_chunk_adder.sv
// chunk_adder: combinational ripple of CHUNK full-adder cells (x + y + cin).
module chunk_adder
  import serial_adder_pkg::*;
#(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit add, CHUNK bits per clock, LSB chunk first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b as a + ~b + 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = ceil_log2(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("serial_adder: CHUNK must be >= 1 and divide WIDTH (WIDTH >= 1)");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               sub_sel;
  logic [CHUNK-1:0]   chunk_s;
  logic               chunk_cout;
  logic [WIDTH+CHUNK-1:0] acc_cat;
  logic [WIDTH-1:0]   acc_shifted;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .x    (a_sh_q[CHUNK-1:0]),
    .y    (b_sh_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  // New chunk enters at the MSB end; works for NCHUNK == 1 as well.
  assign acc_cat     = {chunk_s, acc_q};
  assign acc_shifted = acc_cat[WIDTH+CHUNK-1:CHUNK];

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // b is inverted once at launch, so subtraction needs no per-chunk mux.
          a_sh_d  = a;
          b_sh_d  = sub_sel ? ~b : b;
          carry_d = sub_sel;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        acc_d   = acc_shifted;
        carry_d = chunk_cout;
        if (cnt_q == LAST_CNT) begin
          sum_d   = acc_shifted;
          cout_d  = chunk_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four configurations (8/1, 8/4, 8/2, 16/16) checked
// against an arithmetic reference; SERIAL_ADDER_SUB_EN enables subtract tests.
module tb_serial_adder;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_i [NI];
  logic [15:0]   a_i     [NI];
  logic [15:0]   b_i     [NI];
  logic          sub_i   [NI];
  logic [NI-1:0] busy_o;
  logic [NI-1:0] done_o;
  logic [NI-1:0] co_o;
  logic [7:0]    sum0, sum1, sum2;
  logic [15:0]   sum3;

  int          wid [NI] = '{8, 8, 8, 16};
  int          nch [NI] = '{8, 2, 4, 1};
  logic [15:0] held_sum [NI];
  logic        held_co  [NI];

  int n_cmp = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(8), .CHUNK(1)) u_d0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .a(a_i[0][7:0]), .b(b_i[0][7:0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_i[0]),
`endif
    .busy(busy_o[0]), .done(done_o[0]), .sum(sum0), .carry_out(co_o[0]));

  serial_adder #(.WIDTH(8), .CHUNK(4)) u_d1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .a(a_i[1][7:0]), .b(b_i[1][7:0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_i[1]),
`endif
    .busy(busy_o[1]), .done(done_o[1]), .sum(sum1), .carry_out(co_o[1]));

  serial_adder #(.WIDTH(8), .CHUNK(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start_i[2]), .a(a_i[2][7:0]), .b(b_i[2][7:0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_i[2]),
`endif
    .busy(busy_o[2]), .done(done_o[2]), .sum(sum2), .carry_out(co_o[2]));

  serial_adder #(.WIDTH(16), .CHUNK(16)) u_d3 (
    .clk(clk), .rst(rst), .start(start_i[3]), .a(a_i[3]), .b(b_i[3]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_i[3]),
`endif
    .busy(busy_o[3]), .done(done_o[3]), .sum(sum3), .carry_out(co_o[3]));

  function automatic logic [15:0] sum_of(input int k);
    case (k)
      0:       return {8'h00, sum0};
      1:       return {8'h00, sum1};
      2:       return {8'h00, sum2};
      default: return sum3;
    endcase
  endfunction

  function automatic logic [15:0] mask_of(input int k);
    return (wid[k] == 16) ? 16'hFFFF : 16'h00FF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input int k, input string tag);
    chk({tag, "_busy"}, {31'b0, busy_o[k]}, 32'd0);
    chk({tag, "_done"}, {31'b0, done_o[k]}, 32'd0);
    chk({tag, "_sum"},  {16'b0, sum_of(k)}, {16'b0, held_sum[k]});
    chk({tag, "_co"},   {31'b0, co_o[k]},   {31'b0, held_co[k]});
  endtask

  // Called just after a falling edge; launches, runs and checks one operation,
  // returning at the falling edge of the DONE cycle with start released.
  task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input logic hold);
    logic [15:0] m;
    logic [15:0] es;
    logic        ec;
    logic        sv_eff;
    int          ai, bi;
    m = mask_of(k);
`ifdef SERIAL_ADDER_SUB_EN
    sv_eff = sv;
`else
    sv_eff = 1'b0;
`endif
    ai = int'(av & m);
    bi = int'(bv & m);
    if (sv_eff) begin
      es = 16'(ai - bi) & m;
      ec = (ai >= bi);
    end else begin
      es = 16'(ai + bi) & m;
      ec = ((ai + bi) > int'(m));
    end
    a_i[k] = av & m;
    b_i[k] = bv & m;
    sub_i[k] = sv_eff;
    start_i[k] = 1'b1;
    for (int c = 0; c < nch[k]; c++) begin
      @(negedge clk);
      // Operands wander during the run; they must not be picked up.
      start_i[k] = hold;
      a_i[k] = 16'($urandom) & m;
      b_i[k] = 16'($urandom) & m;
      sub_i[k] = 1'($urandom);
      chk("run_busy", {31'b0, busy_o[k]}, 32'd1);
      chk("run_done", {31'b0, done_o[k]}, 32'd0);
      chk("run_sum_held", {16'b0, sum_of(k)}, {16'b0, held_sum[k]});
      chk("run_co_held", {31'b0, co_o[k]}, {31'b0, held_co[k]});
    end
    @(negedge clk);
    start_i[k] = 1'b0;
    chk("res_done", {31'b0, done_o[k]}, 32'd1);
    chk("res_busy", {31'b0, busy_o[k]}, 32'd0);
    chk("res_sum", {16'b0, sum_of(k)}, {16'b0, es});
    chk("res_co", {31'b0, co_o[k]}, {31'b0, ec});
    held_sum[k] = es;
    held_co[k]  = ec;
    $display("op dut=%0d a=%h b=%h sub=%0d hold=%0d -> sum=%h co=%0d (exp %h/%0d)",
             k, av & m, bv & m, sv_eff, hold, sum_of(k), co_o[k], es, ec);
  endtask

  task automatic finish_op(input int k);
    @(negedge clk);
    chk_quiet(k, "after_done");
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      start_i[k] = 1'b0;
      a_i[k] = '0;
      b_i[k] = '0;
      sub_i[k] = 1'b0;
      held_sum[k] = '0;
      held_co[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) chk_quiet(k, "reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(0, 16'h005A, 16'h0033, 1'b0, 1'b0);
    finish_op(0);
    do_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    finish_op(1);
    do_op(3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    finish_op(3);
`ifdef SERIAL_ADDER_SUB_EN
    do_op(2, 16'h0010, 16'h0020, 1'b1, 1'b0);
    finish_op(2);
    do_op(2, 16'h0020, 16'h0010, 1'b1, 1'b0);
    finish_op(2);
`endif

    // start held high through the run, then back-to-back launch in DONE
    do_op(0, 16'h0001, 16'h0001, 1'b0, 1'b1);
    do_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0);
    finish_op(0);

    // Reset in the middle of a run
    a_i[0] = 16'h00C3;
    b_i[0] = 16'h005C;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      held_sum[k] = '0;
      held_co[k] = 1'b0;
    end
    chk_quiet(0, "midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_done", {31'b0, done_o[0]}, 32'd0);
    end
    do_op(0, 16'h0077, 16'h0099, 1'b0, 1'b0);
    finish_op(0);

    // Randomized operations across all configurations
    for (int t = 0; t < 40; t++) begin
      int k;
      k = int'($urandom_range(NI - 1, 0));
      do_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 1)
        do_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      finish_op(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
